// File: rtl/hdmi_freq_pkg.sv
// Shared types and default thresholds for the HDMI pixel-clock mode detector.
package hdmi_freq_pkg;

  typedef enum logic [1:0] {
    MODE_NONE = 2'd0,
    MODE_1    = 2'd1,
    MODE_2    = 2'd2,
    MODE_3    = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    ST_SEARCH = 2'd0,
    ST_REQ    = 2'd1,
    ST_LOCKED = 2'd2
  } state_e;

  localparam int unsigned DEF_WIN_LOG2       = 3;
  localparam int unsigned DEF_STABLE_WINDOWS = 4;
  localparam int unsigned DEF_HYST           = 2;
  localparam int unsigned DEF_THR_MIN        = 4;
  localparam int unsigned DEF_THR_1          = 20;
  localparam int unsigned DEF_THR_2          = 40;
  localparam int unsigned DEF_ACK_TIMEOUT    = 1023;
  localparam int unsigned FREQ_MAX           = 511;

  // Plain band classification, no hysteresis.
  function automatic mode_e freq_band(input logic [8:0] f,
                                      input logic [8:0] t_min,
                                      input logic [8:0] t1,
                                      input logic [8:0] t2);
    mode_e b;
    if (f < t_min)   b = MODE_NONE;
    else if (f < t1) b = MODE_1;
    else if (f < t2) b = MODE_2;
    else             b = MODE_3;
    return b;
  endfunction

endpackage

// File: rtl/freq_window_avg.sv
// Free-running window averager: sums 2**WIN_LOG2 samples, publishes the
// truncated mean and a one-cycle win_done strobe at the end of each window.
module freq_window_avg
  import hdmi_freq_pkg::*;
#(
  parameter int unsigned WIN_LOG2 = DEF_WIN_LOG2
) (
  input  logic       clk_8,
  input  logic       reset_n,
  input  logic [8:0] freq,
  output logic [8:0] avg_freq,
  output logic       win_done
);

  localparam int unsigned ACC_W = 9 + WIN_LOG2;

  logic [WIN_LOG2-1:0] wcnt_q, wcnt_d;
  logic [ACC_W-1:0]    acc_q, acc_d;
  logic [8:0]          avg_q, avg_d;
  logic                done_q, done_d;
  logic [ACC_W-1:0]    sum;
  logic                last;

  always_comb begin
    sum    = acc_q + ACC_W'(freq);
    last   = (wcnt_q == '1);
    wcnt_d = wcnt_q + WIN_LOG2'(1);
    acc_d  = last ? '0 : sum;
    avg_d  = last ? sum[WIN_LOG2 +: 9] : avg_q;
    done_d = last;
  end

  always_ff @(posedge clk_8 or negedge reset_n) begin
    if (!reset_n) begin
      wcnt_q <= '0;
      acc_q  <= '0;
      avg_q  <= '0;
      done_q <= 1'b0;
    end else begin
      wcnt_q <= wcnt_d;
      acc_q  <= acc_d;
      avg_q  <= avg_d;
      done_q <= done_d;
    end
  end

  assign avg_freq = avg_q;
  assign win_done = done_q;

endmodule

// File: rtl/hdmi_freq_mode_detect.sv
// Classifies the averaged pixel-clock frequency into a mode with hysteresis and
// debounce, and hands stable mode changes to the PLL via a req/ack handshake.
module hdmi_freq_mode_detect
  import hdmi_freq_pkg::*;
#(
  parameter int unsigned WIN_LOG2       = DEF_WIN_LOG2,
  parameter int unsigned STABLE_WINDOWS = DEF_STABLE_WINDOWS,
  parameter int unsigned HYST           = DEF_HYST,
  parameter int unsigned THR_MIN        = DEF_THR_MIN,
  parameter int unsigned THR_1          = DEF_THR_1,
  parameter int unsigned THR_2          = DEF_THR_2,
  parameter int unsigned ACK_TIMEOUT    = DEF_ACK_TIMEOUT
) (
  input  logic       clk_8,
  input  logic       reset_n,
  input  logic [8:0] freq,
  input  logic       reconfig_ack,
  output logic [1:0] mode,
  output logic       mode_valid,
  output logic       reconfig_req,
  output logic [8:0] avg_freq,
  output logic       timeout_err
);

  localparam int unsigned       STAB_W   = $clog2(STABLE_WINDOWS + 1);
  localparam logic [STAB_W-1:0] STAB_MAX = STAB_W'(STABLE_WINDOWS);
  localparam int unsigned       TO_W     = $clog2(ACK_TIMEOUT + 1);
  localparam logic [TO_W-1:0]   TO_LAST  = TO_W'(ACK_TIMEOUT - 1);
  localparam logic [9:0]        T_MIN    = 10'(THR_MIN);
  localparam logic [9:0]        T_1      = 10'(THR_1);
  localparam logic [9:0]        T_2      = 10'(THR_2);
  localparam logic [9:0]        T_TOP    = 10'(FREQ_MAX);
  localparam logic [9:0]        H        = 10'(HYST);

  logic [8:0] avg_w;
  logic       win_done;

  freq_window_avg #(.WIN_LOG2(WIN_LOG2)) u_win (
    .clk_8    (clk_8),
    .reset_n  (reset_n),
    .freq     (freq),
    .avg_freq (avg_w),
    .win_done (win_done)
  );

  state_e            state_q, state_d;
  mode_e             mode_q, mode_d;
  mode_e             pending_q, pending_d;
  logic [STAB_W-1:0] stab_q, stab_d;
  logic [TO_W-1:0]   tcnt_q, tcnt_d;
  logic              req_q, req_d;
  logic              valid_q, valid_d;
  logic              terr_q, terr_d;

  logic [9:0] lo, hi, lo_sat, hi_sum, hi_sat;
  logic       in_hyst;
  mode_e      cand;
  logic       settled;

  // Hysteresis band around the locked mode, saturated to the 0..511 range.
  always_comb begin
    lo = '0;
    hi = '0;
    unique case (mode_q)
      MODE_1:  begin lo = T_MIN; hi = T_1;   end
      MODE_2:  begin lo = T_1;   hi = T_2;   end
      MODE_3:  begin lo = T_2;   hi = T_TOP; end
      default: begin lo = '0;    hi = '0;    end
    endcase
    lo_sat  = (lo > H) ? (lo - H) : '0;
    hi_sum  = hi + H;
    hi_sat  = (hi_sum > T_TOP) ? T_TOP : hi_sum;
    in_hyst = ({1'b0, avg_w} >= lo_sat) && ({1'b0, avg_w} < hi_sat);
  end

  always_comb begin
    cand = freq_band(avg_w, T_MIN[8:0], T_1[8:0], T_2[8:0]);
    if (state_q == ST_LOCKED && in_hyst) cand = mode_q;

    pending_d = pending_q;
    stab_d    = stab_q;
    if (win_done) begin
      if (cand == pending_q) begin
        if (stab_q != STAB_MAX) stab_d = stab_q + STAB_W'(1);
      end else begin
        pending_d = cand;
        stab_d    = STAB_W'(1);
      end
    end
    settled = win_done && (stab_d == STAB_MAX);

    state_d = state_q;
    mode_d  = mode_q;
    req_d   = req_q;
    tcnt_d  = tcnt_q;
    terr_d  = 1'b0;

    unique case (state_q)
      ST_SEARCH: begin
        if (settled && pending_d != MODE_NONE) begin
          mode_d  = pending_d;
          req_d   = 1'b1;
          tcnt_d  = '0;
          state_d = ST_REQ;
        end
      end
      ST_REQ: begin
        if (reconfig_ack) begin
          req_d   = 1'b0;
          state_d = ST_LOCKED;
        end else if (tcnt_q == TO_LAST) begin
          req_d     = 1'b0;
          mode_d    = MODE_NONE;
          terr_d    = 1'b1;
          state_d   = ST_SEARCH;
          // Forget the stale debounce history so reacquisition needs a full run.
          pending_d = MODE_NONE;
          stab_d    = '0;
        end else begin
          tcnt_d = tcnt_q + TO_W'(1);
        end
      end
      ST_LOCKED: begin
        if (settled && pending_d != mode_q) begin
          if (pending_d == MODE_NONE) begin
            mode_d  = MODE_NONE;
            state_d = ST_SEARCH;
          end else begin
            mode_d  = pending_d;
            req_d   = 1'b1;
            tcnt_d  = '0;
            state_d = ST_REQ;
          end
        end
      end
      default: begin
        state_d = ST_SEARCH;
        mode_d  = MODE_NONE;
        req_d   = 1'b0;
      end
    endcase

    valid_d = (state_d == ST_LOCKED);
  end

  always_ff @(posedge clk_8 or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_SEARCH;
      mode_q    <= MODE_NONE;
      pending_q <= MODE_NONE;
      stab_q    <= '0;
      tcnt_q    <= '0;
      req_q     <= 1'b0;
      valid_q   <= 1'b0;
      terr_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      mode_q    <= mode_d;
      pending_q <= pending_d;
      stab_q    <= stab_d;
      tcnt_q    <= tcnt_d;
      req_q     <= req_d;
      valid_q   <= valid_d;
      terr_q    <= terr_d;
    end
  end

  assign mode         = mode_q;
  assign mode_valid   = valid_q;
  assign reconfig_req = req_q;
  assign avg_freq     = avg_w;
  assign timeout_err  = terr_q;

endmodule
